// File: rtl/seq_array_mult_if.sv
// Handshake bundle for seq_array_mult: operand channel in, product channel out.
interface seq_array_mult_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Producer/consumer side (testbench or upstream/downstream logic).
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_array_mult.sv
// Sequential shift-add multiplier: one partial-product row per clock, WIDTH
// RUN cycles per operation, unsigned or two's-complement via sign-magnitude.
module seq_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_array_mult_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Absolute value as an unsigned WIDTH-bit number; the most negative value
  // maps onto 2^(WIDTH-1), which is still representable unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
    negate = ~v + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_r;
  logic [PW-1:0]   mag_a_r;     // multiplicand magnitude, pre-shifted to current row
  logic [WIDTH-1:0] mag_b_r;    // multiplier magnitude, LSB is the current row bit
  logic            sign_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic [PW-1:0]   product_r;

  logic [PW-1:0]   addend_s;
  logic [PW-1:0]   acc_sum_s;
  logic [PW-1:0]   final_s;

  // Current partial-product row, running sum, and sign-corrected result.
  always_comb begin
    addend_s  = {PW{1'b0}};
    acc_sum_s = {PW{1'b0}};
    final_s   = {PW{1'b0}};
    if (mag_b_r[0]) begin
      addend_s = mag_a_r;
    end else begin
      addend_s = {PW{1'b0}};
    end
    acc_sum_s = acc_r + addend_s;
    if (sign_r) begin
      final_s = negate(acc_sum_s);
    end else begin
      final_s = acc_sum_s;
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mag_a_r     <= {PW{1'b0}};
      mag_b_r     <= {WIDTH{1'b0}};
      sign_r      <= 1'b0;
      acc_r       <= {PW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      product_r   <= {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            mag_a_r     <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.signed_mode)};
            mag_b_r     <= magnitude(bus.b, bus.signed_mode);
            sign_r      <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc_r       <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= RUN;
          end else begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        RUN: begin
          acc_r   <= acc_sum_s;
          mag_a_r <= {mag_a_r[PW-2:0], 1'b0};
          mag_b_r <= {1'b0, mag_b_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ROW) begin
            product_r   <= final_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= RUN;
          end
        end
        DONE: begin
          // Output handshake only; new operands wait for the next IDLE cycle.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.product   = product_r;
endmodule

// File: tb/tb_seq_array_mult.sv
// Directed and back-to-back checks of seq_array_mult at WIDTH=4 and WIDTH=8.
module tb_seq_array_mult;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_array_mult_if #(.WIDTH(4)) bus4 ();
  seq_array_mult_if #(.WIDTH(8)) bus8 ();

  seq_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  seq_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } exp_t;

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if something wedges the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference 8x8 product using the simulator's own integer multiply.
  function automatic logic [15:0] ref_mult8(input logic [7:0] a, input logic [7:0] b,
                                            input logic sm);
    int sa;
    int sb;
    sa = sm ? int'($signed(a)) : int'(a);
    sb = sm ? int'($signed(b)) : int'(b);
    ref_mult8 = 16'(sa * sb);
  endfunction

  // One WIDTH=4 operation; called at a falling edge, returns at a falling edge.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                         output logic [7:0] prod, output int lat,
                         output logic busy_done, output logic rdy_after,
                         output logic ov_after);
    int guard;
    guard = 0;
    while (bus4.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus4.a = a;
    bus4.b = b;
    bus4.signed_mode = sm;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    prod = bus4.product;
    busy_done = bus4.busy;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    rdy_after = bus4.in_ready;
    ov_after = bus4.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.signed_mode = 1'b0;
    bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.signed_mode = 1'b0;
    bus8.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus4.in_ready);
    end
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", bus4.out_valid);
    end
    checks++;
    if (bus4.product !== 8'h00) begin
      errors++; $display("FAIL reset_product got %h want 00", bus4.product);
    end
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", bus4.busy);
    end
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_w8 got rdy=%b ov=%b want rdy=1 ov=0",
                         bus8.in_ready, bus8.out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [7:0] prod;
    int lat;
    logic bz, rdy, ov;
    run_op4(4'd13, 4'd11, 1'b0, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'h8F) begin errors++; $display("FAIL u_13x11 got %h want 8f", prod); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL u_latency got %0d want 4", lat); end
    checks++;
    if (bz !== 1'b1) begin errors++; $display("FAIL u_busy_done got %b want 1", bz); end
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL u_handshake got rdy=%b ov=%b want rdy=1 ov=0", rdy, ov);
    end
    run_op4(4'd15, 4'd15, 1'b0, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'hE1) begin errors++; $display("FAIL u_15x15 got %h want e1", prod); end
    run_op4(4'd0, 4'd9, 1'b0, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'h00) begin errors++; $display("FAIL u_0x9 got %h want 00", prod); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL u_zero_latency got %0d want 4", lat); end
  endtask

  task automatic test_signed();
    logic [7:0] prod;
    int lat;
    logic bz, rdy, ov;
    run_op4(4'h8, 4'h8, 1'b1, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'h40) begin errors++; $display("FAIL s_m8xm8 got %h want 40", prod); end
    run_op4(4'hD, 4'h5, 1'b1, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'hF1) begin errors++; $display("FAIL s_m3x5 got %h want f1", prod); end
    run_op4(4'h7, 4'hF, 1'b1, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'hF9) begin errors++; $display("FAIL s_7xm1 got %h want f9", prod); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL s_latency got %0d want 4", lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    bus4.a = 4'd5; bus4.b = 4'd3; bus4.signed_mode = 1'b0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
      bus4.a = 4'd9; bus4.b = 4'd9;
      @(negedge clk);
      checks++;
      if (bus4.product !== 8'h0F || bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got prod=%h ov=%b rdy=%b want prod=0f ov=1 rdy=0",
                 i, bus4.product, bus4.out_valid, bus4.in_ready);
      end
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.product !== 8'h0F) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b prod=%h want rdy=1 ov=0 prod=0f",
               bus4.in_ready, bus4.out_valid, bus4.product);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] prod;
    int lat;
    logic bz, rdy, ov;
    bus4.a = 4'd9; bus4.b = 4'd9; bus4.signed_mode = 1'b0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.product !== 8'h00 ||
        bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b ov=%b prod=%h busy=%b want rdy=1 ov=0 prod=00 busy=0",
               bus4.in_ready, bus4.out_valid, bus4.product, bus4.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrun_discard got ov=%b want 0", bus4.out_valid);
    end
    run_op4(4'd6, 4'd7, 1'b0, prod, lat, bz, rdy, ov);
    checks++;
    if (prod !== 8'h2A) begin errors++; $display("FAIL midrun_6x7 got %h want 2a", prod); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL midrun_latency got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int got;
    int cyc;
    int last_ov;
    int npush;
    got = 0;
    cyc = 0;
    last_ov = -1;
    npush = 0;
    bus8.out_ready = 1'b1;
    bus8.in_valid = 1'b1;
    while (got < 200 && cyc < 2500) begin
      if (bus8.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got prod=%h with no pending operation",
                             bus8.product);
        end else begin
          e = q.pop_front();
          if (bus8.product !== e.exp) begin
            errors++;
            $display("FAIL b2b_product #%0d a=%h b=%h sm=%b got %h want %h",
                     got, e.a, e.b, e.sm, bus8.product, e.exp);
          end
        end
        if (last_ov >= 0) begin
          checks++;
          if (cyc - last_ov != 10) begin
            errors++; $display("FAIL b2b_interval got %0d want 10", cyc - last_ov);
          end
        end
        last_ov = cyc;
        got++;
      end
      e.a = 8'($urandom);
      e.b = 8'($urandom);
      e.sm = 1'($urandom);
      if (bus8.in_ready === 1'b1) begin
        case (npush)
          0: begin e.a = 8'h80; e.b = 8'h80; e.sm = 1'b1; end
          1: begin e.a = 8'hFF; e.b = 8'hFF; e.sm = 1'b0; end
          2: begin e.a = 8'hFF; e.b = 8'hFF; e.sm = 1'b1; end
          3: begin e.a = 8'h80; e.b = 8'h7F; e.sm = 1'b1; end
          default: begin end
        endcase
        e.exp = ref_mult8(e.a, e.b, e.sm);
        q.push_back(e);
        npush++;
      end
      bus8.a = e.a;
      bus8.b = e.b;
      bus8.signed_mode = e.sm;
      @(negedge clk);
      cyc++;
    end
    bus8.in_valid = 1'b0;
    checks++;
    if (got != 200) begin
      errors++; $display("FAIL b2b_count got %0d products want 200", got);
    end
    repeat (12) @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask

  // Test sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
